bin_share_arbiter: RTL and testbench
====================================

Name: bin_share_arbiter

Overview:
- Shares one registered WIDTH-bit adder (the Bin unit) among NUM_REQ requesters, so independent schedules can time-multiplex a single adder instead of each instantiating its own.
- Round-robin arbitration with a req/gnt handshake on the issue side and a single valid/ready result port tagged with the requester id.
- Sits between per-requester state machines and the shared adder; it owns the adder's input muxes and its output register.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 13, operand and result width in bits.
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  request vector. req[i] means in0[i]/in1[i] are valid.
- in0  in  NUM_REQ*WIDTH  flattened first operands; slice i is [i*WIDTH +: WIDTH].
- in1  in  NUM_REQ*WIDTH  flattened second operands, same slicing.
- gnt  out  NUM_REQ  one-hot grant. It is combinational from req, rr_ptr and slot state.
- resp_valid  out  1  result slot holds an unconsumed sum.
- resp_ready  in  1  consumer accepts the slot this cycle.
- resp_id  out  ID_W  index of the requester that owns resp_data.
- resp_data  out  WIDTH  the registered sum.
- busy  out  1  resp_valid OR any req bit high.

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - resp_valid=0, resp_id=0, resp_data=0, rr_ptr=0, state=IDLE.
  - All counters to 0 (when the counter feature is enabled).
  - gnt is forced to 0 in any cycle where rst_n=0.
- State machine has two states:
  - IDLE: slot empty.
  - FULL: slot holds a result.
  - IDLE→FULL on an issue.
  - FULL→IDLE when resp_ready is high and there is no issue in the same cycle.
  - FULL→FULL when resp_ready is high and an issue happens in the same cycle (back-to-back).
  - FULL stays FULL with contents frozen while resp_ready is low.
- Issue condition is: any req high AND (state==IDLE OR resp_ready==1).
- Grant selection:
  - gnt[i]=1 for the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - gnt is all zeros when the issue condition is false.
- On an issue at posedge:
  - resp_data <= in0[k]+in1[k] modulo 2^WIDTH (carry dropped), where k is the granted index.
  - resp_id <= k; resp_valid <= 1.
  - rr_ptr <= (k+1) mod NUM_REQ.
- rr_ptr is unchanged when no issue occurs.
- Latency is 1 cycle: a grant in cycle t gives resp_valid=1 in cycle t+1.
- Throughput is one add per cycle while resp_ready stays high.
- Requester rules:
  - A requester holds req and its operands stable until it sees gnt[i]=1 at a posedge.
  - It may drop req in the cycle after the grant or keep it asserted for the next operation.
  - Dropping req before it is granted is permitted; no state is left behind.
- Boundary conditions:
  - All req low: gnt=0 and resp_valid is unaffected.
  - Single requester asserting req continuously: it is granted every cycle that slot space allows.
  - NUM_REQ not a power of two: the rr_ptr wrap is an explicit compare, not a bit truncation.
  - Reset mid-operation: a pending result is discarded with no response, and arbitration restarts from requester 0.
- resp_id and resp_data are don't-care while resp_valid=0, but are still driven by the register (never X after reset).

Optional Feature:
- Macro: BIN_SHARE_STATS_EN.
- With the macro defined:
  - Adds output stat_issue (NUM_REQ*16 bits). Slice i is a saturating 16-bit count of grants to requester i.
  - Adds output stat_stall (16 bits). It is a saturating count of cycles with any req high but no issue.
  - Counters saturate at 16'hFFFF and clear on reset.
- Without the macro: neither port nor the counters exist, and the remaining behaviour is identical.

Decomposition:
- Package bin_share_pkg holds:
  - The state enum {IDLE, FULL}.
  - The localparam STAT_W=16.
  - A function rr_pick(req, ptr) that returns the granted index plus a found flag.
- One sub-module, bin_share_rr, holds the round-robin picker and pointer register.
- The adder, output slot and FSM stay in the top module.

Test Plan:
- Basic add: NUM_REQ=4, WIDTH=13, req=4'b0001, in0[0]=10, in1[0]=20, resp_ready=1. Expect gnt=0001 the same cycle; next cycle resp_valid=1, resp_id=0, resp_data=30.
- Wrap-around: in0[2]=13'h1FFF, in1[2]=2. Expect resp_data=1 with the carry dropped.
- Round-robin fairness: req=1111 held for 8 cycles with resp_ready=1. Expect gnt sequence 0001,0010,0100,1000,0001,… and resp_id sequence 0,1,2,3,0,…
- Backpressure: slot FULL, resp_ready=0 for 3 cycles, req=0010. Expect gnt=0 and resp_data frozen. On resp_ready=1, gnt=0010 in that same cycle and the new result appears the next cycle.
- Reset mid-stream: assert rst_n=0 while resp_valid=1. Next cycle expect resp_valid=0 and gnt=0. After release with req=1000, expect the first grant to go to requester 3 (the scan starts from ptr 0).
- With BIN_SHARE_STATS_EN: 3 grants to requester 1 and 2 stalled cycles. Expect stat_issue slice 1 = 3 and stat_stall = 2. Force 70000 issues and expect the slice to saturate at 16'hFFFF.

Source files
------------

// File: rtl/bin_share_pkg.sv
// Purpose: shared types and helpers for the bin_share_arbiter slice (slot FSM states, stat width, round-robin pick).
// Latency: n/a (types and a combinational helper function only).
// Backpressure: n/a.
// Contents: state_t {IDLE, FULL}; STAT_W; pick_t; rr_pick(req, ptr, n) -> {found, idx}.
package bin_share_pkg;

  localparam int STAT_W  = 16;
  // Upper bound on requester count; rr_pick works on a padded vector of this size.
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1, ... modulo n. Offsets are walked
  // from far to near so the nearest hit is the last one written. The wrap is an
  // explicit subtract so non power-of-two n is handled correctly.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0]         ptr,
                                    input int                 n);
    pick_t p;
    int    c;
    p = '0;
    for (int off = MAX_REQ - 1; off >= 0; off--) begin
      c = int'(ptr) + off;
      if (c >= n) c = c - n;
      if ((off < n) && req[c[2:0]]) begin
        p.found = 1'b1;
        p.idx   = c[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bin_share_rr.sv
// Purpose: round-robin picker and rotating priority pointer for the shared adder.
// Latency: grant is combinational from req/rr_ptr/allow; pointer updates at the posedge of an issue.
// Backpressure: allow=0 suppresses every grant and freezes the pointer.
// Ports: clk, rst_n (sync, active low), req, allow, gnt (one-hot), issue, gnt_id.
module bin_share_rr
  import bin_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               allow,
  output logic [NUM_REQ-1:0] gnt,
  output logic               issue,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0]    rr_ptr;
  logic [MAX_REQ-1:0] req_pad;
  pick_t              pick;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req;
    pick                   = rr_pick(req_pad, 3'(rr_ptr), NUM_REQ);
  end

  // rst_n gates the grant so nothing is granted during a reset cycle.
  assign issue  = pick.found & allow & rst_n;
  assign gnt_id = ID_W'(pick.idx);

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = issue && (int'(pick.idx) == i);
    end
  end

  // Next scan starts just after the winner; wrap by compare, not truncation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/bin_share_arbiter.sv
// Purpose: time-multiplexes one registered WIDTH-bit adder among NUM_REQ requesters, round-robin.
// Latency: 1 cycle from grant to resp_valid; one add per cycle while resp_ready stays high.
// Backpressure: a full slot with resp_ready=0 blocks all grants and freezes resp_id/resp_data.
// Ports: clk, rst_n (sync, active low); req/in0/in1 -> gnt; resp_valid/resp_ready/resp_id/resp_data; busy.
// Optional: define BIN_SHARE_STATS_EN to add stat_issue (per-requester grant counts) and stat_stall.
module bin_share_arbiter
  import bin_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 13,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   in0,
  input  logic [NUM_REQ*WIDTH-1:0]   in1,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       busy
`ifdef BIN_SHARE_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]  stat_issue,
  output logic [STAT_W-1:0]          stat_stall
`endif
);

  state_t          state;
  state_t          state_nxt;
  logic            allow;
  logic            issue;
  logic [ID_W-1:0] gnt_id;
  logic [WIDTH-1:0] sum;

  bin_share_rr #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .allow  (allow),
    .gnt    (gnt),
    .issue  (issue),
    .gnt_id (gnt_id)
  );

  // Slot FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Slot FSM: next state. An issue always refills the slot, even when the old
  // result is consumed in the same cycle.
  always_comb begin
    state_nxt = state;
    if (issue)                             state_nxt = FULL;
    else if (state == FULL && resp_ready)  state_nxt = IDLE;
  end

  // Slot FSM: outputs. The slot can take a new sum when empty or being drained.
  always_comb begin
    allow      = (state == IDLE) || resp_ready;
    resp_valid = (state == FULL);
  end

  assign busy = resp_valid | (|req);

  // Shared adder; carry out is dropped.
  assign sum = in0[int'(gnt_id)*WIDTH +: WIDTH] + in1[int'(gnt_id)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_id   <= '0;
      resp_data <= '0;
    end else if (issue) begin
      resp_id   <= gnt_id;
      resp_data <= sum;
    end
  end

`ifdef BIN_SHARE_STATS_EN
  // Saturating counters: grants per requester, and cycles where someone asked but nothing issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (stat_issue[i*STAT_W +: STAT_W] != '1)) begin
          stat_issue[i*STAT_W +: STAT_W] <= stat_issue[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
      if ((|req) && !issue && (stat_stall != '1)) begin
        stat_stall <= stat_stall + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bin_share_arbiter.sv
// Purpose: self-checking bench for bin_share_arbiter (NUM_REQ=4, WIDTH=13): vector table plus hand sequences.
// Latency: expected results queue at grant time and are compared while the DUT holds them valid.
// Backpressure: resp_ready is part of each vector; held results must stay frozen until consumed.
module tb_bin_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 13;
  localparam int IW = 2;
  localparam int NV = 27;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0][W-1:0] in0 = '0;
  logic [N-1:0][W-1:0] in1 = '0;
  logic [N-1:0]        gnt;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [IW-1:0]       resp_id;
  logic [W-1:0]        resp_data;
  logic                busy;
`ifdef BIN_SHARE_STATS_EN
  logic [N*16-1:0]     stat_issue;
  logic [15:0]         stat_stall;
`endif

  bin_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .in0        (in0),
    .in1        (in1),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
`ifdef BIN_SHARE_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]        req;
    logic [N-1:0][W-1:0] a;
    logic [N-1:0][W-1:0] b;
    logic                rdy;
    logic [N-1:0]        eg;
  } vec_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
  } exp_t;

  vec_t                tbl [NV];
  exp_t                sb [$];
  int                  nvec = 0;
  int                  nerr = 0;
  logic [N-1:0][W-1:0] ra;
  logic [N-1:0][W-1:0] rb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void setv(input int v, input logic [N-1:0] r, input logic rdy, input logic [N-1:0] eg);
    tbl[v].req = r;
    tbl[v].rdy = rdy;
    tbl[v].eg  = eg;
  endfunction

  // One cycle: drive at negedge, check combinational grant and the held result,
  // queue the expected sum for a grant, then let the posedge happen.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0][W-1:0] a,
                      input logic [N-1:0][W-1:0] b, input logic rdy, input logic rn,
                      input logic [N-1:0] eg);
    exp_t e;
    int   k;
    @(negedge clk);
    req = r; in0 = a; in1 = b; resp_ready = rdy; rst_n = rn;
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("resp_valid", 32'(resp_valid), 32'(sb.size() != 0));
    chk("busy", 32'(busy), 32'((sb.size() != 0) || (|r)));
    if (resp_valid && sb.size() != 0) begin
      chk("resp_id", 32'(resp_id), 32'(sb[0].id));
      chk("resp_data", 32'(resp_data), 32'(sb[0].sum));
      if (rdy) sb.delete(0);
    end
    k = -1;
    for (int i = 0; i < N; i++) if (eg[i]) k = i;
    if (k >= 0) begin
      e.id  = IW'(k);
      e.sum = a[k] + b[k];
      sb.push_back(e);
    end
    @(posedge clk);
    if (!rn) sb.delete();
  endtask

  task automatic hstep(input logic [N-1:0] r, input logic rdy, input logic rn, input logic [N-1:0] eg);
    for (int i = 0; i < N; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
    end
    step(r, ra, rb, rdy, rn, eg);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Table: random operands everywhere, then the directed values.
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < N; i++) begin
        tbl[v].a[i] = W'($urandom);
        tbl[v].b[i] = W'($urandom);
      end
      setv(v, 4'b0000, 1'b1, 4'b0000);
    end
    setv(0, 4'b0001, 1'b1, 4'b0001); tbl[0].a[0] = 13'd10;    tbl[0].b[0] = 13'd20;
    setv(2, 4'b0100, 1'b1, 4'b0100); tbl[2].a[2] = 13'h1FFF;  tbl[2].b[2] = 13'd2;
    setv(4, 4'b1000, 1'b1, 4'b1000);
    for (int v = 5; v < 13; v++) setv(v, 4'b1111, 1'b1, 4'(1 << ((v - 5) % 4)));
    for (int v = 13; v < 16; v++) setv(v, 4'b0010, 1'b0, 4'b0000);
    setv(16, 4'b0010, 1'b1, 4'b0010);
    setv(17, 4'b0000, 1'b0, 4'b0000);
    setv(18, 4'b0001, 1'b0, 4'b0000);
    setv(20, 4'b0001, 1'b0, 4'b0001);
    setv(21, 4'b0011, 1'b1, 4'b0010);
    for (int v = 23; v < 26; v++) setv(v, 4'b0100, 1'b1, 4'b0100);

    // Reset state, with requests pending to show gnt is held low.
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);

    for (int v = 0; v < NV; v++) begin
      step(tbl[v].req, tbl[v].a, tbl[v].b, tbl[v].rdy, 1'b1, tbl[v].eg);
    end

    // Reset mid-stream: pointer is 3 before, so req=1010 distinguishes a restart from 0.
    hstep(4'b0100, 1'b1, 1'b1, 4'b0100);
    hstep(4'b0001, 1'b0, 1'b0, 4'b0000);
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_id", 32'(resp_id), 32'd0);
    chk("mid_rst_data", 32'(resp_data), 32'd0);
    hstep(4'b1010, 1'b1, 1'b1, 4'b0010);
    hstep(4'b1000, 1'b1, 1'b1, 4'b1000);

    // Two more grants to requester 1, then two stalled cycles behind a full slot.
    hstep(4'b0010, 1'b1, 1'b1, 4'b0010);
    hstep(4'b0010, 1'b1, 1'b1, 4'b0010);
    hstep(4'b0010, 1'b0, 1'b1, 4'b0000);
    hstep(4'b0010, 1'b0, 1'b1, 4'b0000);
    hstep(4'b0000, 1'b1, 1'b1, 4'b0000);
    hstep(4'b0000, 1'b1, 1'b1, 4'b0000);

`ifdef BIN_SHARE_STATS_EN
    #1;
    chk("stat_issue1", 32'(stat_issue[1*16 +: 16]), 32'd3);
    chk("stat_issue3", 32'(stat_issue[3*16 +: 16]), 32'd1);
    chk("stat_issue0", 32'(stat_issue[0*16 +: 16]), 32'd0);
    chk("stat_stall", 32'(stat_stall), 32'd2);
    @(negedge clk);
    req = 4'b0001; resp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("stat_sat0", 32'(stat_issue[0*16 +: 16]), 32'hFFFF);
    chk("stat_stall_hold", 32'(stat_stall), 32'd2);
    @(negedge clk);
    req = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
